// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking synapse/neuron blocks.
// Holds the synapse FSM states, datapath width and saturating add.
package snn_pkg;

    localparam int CW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REFR  = 2'd1,
        DECAY = 2'd2
    } syn_state_e;

    function automatic logic [CW-1:0] sat_add(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b
    );
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

endpackage

// File: rtl/spike_synapse_if.sv
// Spike/weight inputs and current outputs of the synapse.
// The master drives spikes and weights; the slave is the synapse.
interface spike_synapse_if
    import snn_pkg::*;
();
    logic          spike_in;
    logic          weight_load;
    logic [CW-1:0] weight_in;
    logic [CW-1:0] current_out;
    logic          spike_seen;
    logic          active;

    modport master (
        output spike_in,
        output weight_load,
        output weight_in,
        input  current_out,
        input  spike_seen,
        input  active
    );

    modport slave (
        input  spike_in,
        input  weight_load,
        input  weight_in,
        output current_out,
        output spike_seen,
        output active
    );
endinterface

// File: rtl/synapse_decay_step.sv
// One exponential decay step: cur - max(cur >> shift, 1), floored at 0.
// Also usable by the neuron leak path.
module synapse_decay_step
    import snn_pkg::*;
(
    input  logic [CW-1:0] cur,
    input  logic [2:0]    shift,
    output logic [CW-1:0] nxt
);
    logic [CW-1:0] d;

    always_comb begin
        d = cur >> shift;
        // Small values still reach zero instead of stalling.
        if (d == '0 && cur != '0) begin
            d = {{(CW-1){1'b0}}, 1'b1};
        end
        nxt = cur - d;
    end
endmodule

// File: rtl/spike_synapse.sv
// Postsynaptic current generator: weighted, saturating spike
// accumulation with refractory window and prescaled decay.
module spike_synapse
    import snn_pkg::*;
#(
    parameter logic [7:0] WEIGHT       = 8'h20,
    parameter int         DECAY_SHIFT  = 3,
    parameter int         DECAY_PERIOD = 4,
    parameter int         REFRACT      = 2
) (
    input  logic             clk,
    input  logic             rst,
    spike_synapse_if.slave   bus
);
    localparam int PW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DECAY_PERIOD - 1);
    localparam logic [RW-1:0] REFR_INIT = RW'(REFRACT - 1);

    syn_state_e    state_q, state_d;
    logic [CW-1:0] current_q, current_d;
    logic [CW-1:0] weight_q, weight_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] refr_q, refr_d;
    logic          spike_prev_q, spike_prev_d;
    logic          spike_seen_q, spike_seen_d;
    logic          active_q, active_d;

    logic          rise;
    logic          accept;
    logic          tick;
    logic [CW-1:0] dec_cur;
    logic [CW-1:0] cur_dec;

    synapse_decay_step u_decay (
        .cur   (current_q),
        .shift (3'(DECAY_SHIFT)),
        .nxt   (dec_cur)
    );

    always_comb begin
        rise    = bus.spike_in & ~spike_prev_q;
        accept  = rise && (state_q != REFR);
        tick    = (state_q != IDLE) && (presc_q == PRESC_MAX);
        // Decay is applied before the new spike's weight.
        cur_dec = tick ? dec_cur : current_q;

        current_d    = accept ? sat_add(cur_dec, weight_q) : cur_dec;
        weight_d     = bus.weight_load ? bus.weight_in : weight_q;
        spike_prev_d = bus.spike_in;
        spike_seen_d = accept;
        state_d      = state_q;
        refr_d       = refr_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REFR;
                    refr_d  = REFR_INIT;
                end
            end
            REFR: begin
                if (refr_q == '0) begin
                    state_d = (current_d != '0) ? DECAY : IDLE;
                end else begin
                    refr_d = refr_q - 1'b1;
                end
            end
            DECAY: begin
                if (accept) begin
                    state_d = REFR;
                    refr_d  = REFR_INIT;
                end else if (current_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE || state_d == IDLE) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            current_q    <= '0;
            weight_q     <= WEIGHT;
            presc_q      <= '0;
            refr_q       <= '0;
            spike_prev_q <= 1'b0;
            spike_seen_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            current_q    <= current_d;
            weight_q     <= weight_d;
            presc_q      <= presc_d;
            refr_q       <= refr_d;
            spike_prev_q <= spike_prev_d;
            spike_seen_q <= spike_seen_d;
            active_q     <= active_d;
        end
    end

    assign bus.current_out = current_q;
    assign bus.spike_seen  = spike_seen_q;
    assign bus.active      = active_q;
endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: vector table, corner
// sequences and a randomized run against a behavioural model.
module tb_spike_synapse;
    localparam int P  = 4;
    localparam int SH = 3;
    localparam int RF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    spike_synapse_if bus ();

    spike_synapse #(
        .WEIGHT      (8'h20),
        .DECAY_SHIFT (SH),
        .DECAY_PERIOD(P),
        .REFRACT     (RF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         s;
        bit         wl;
        logic [7:0] wi;
        logic [7:0] cur;
        bit         seen;
        bit         act;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit wl, input logic [7:0] wi);
        bus.spike_in    = s;
        bus.weight_load = wl;
        bus.weight_in   = wi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.spike_in    = 1'b0;
        bus.weight_load = 1'b0;
        bus.weight_in   = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: episode age counts edges since activation.
    int m_cur, m_w, m_rem, m_age;
    bit m_prev, m_act, m_seen;

    function automatic void m_init();
        m_cur = 0; m_w = 'h20; m_rem = 0; m_age = 0;
        m_prev = 0; m_act = 0; m_seen = 0;
    endfunction

    function automatic void m_step(input bit s, input bit wl, input int wi);
        bit rising, acc, was;
        int d;
        rising = s && !m_prev;
        m_prev = s;
        acc    = rising && (m_rem == 0);
        was    = m_act;
        if (was) begin
            m_age++;
            if (m_age % P == 0) begin
                d = m_cur >> SH;
                if (d == 0 && m_cur != 0) d = 1;
                m_cur = m_cur - d;
            end
        end
        if (m_rem > 0) m_rem--;
        if (acc) begin
            if (!was) m_age = 0;
            m_cur = m_cur + m_w;
            if (m_cur > 255) m_cur = 255;
            m_rem = RF;
        end
        if (wl) m_w = wi;
        m_seen = acc;
        m_act  = (m_rem > 0) || (m_cur > 0);
    endfunction

    initial begin
        int seen_cnt;
        bit s, wl;
        int wi;

        vt[0] = '{1, 0, 8'h00, 8'h20, 1, 1};
        vt[1] = '{0, 0, 8'h00, 8'h20, 0, 1};
        vt[2] = '{0, 0, 8'h00, 8'h20, 0, 1};
        vt[3] = '{0, 0, 8'h00, 8'h20, 0, 1};
        vt[4] = '{0, 0, 8'h00, 8'h1C, 0, 1};
        vt[5] = '{0, 0, 8'h00, 8'h1C, 0, 1};
        vt[6] = '{0, 0, 8'h00, 8'h1C, 0, 1};
        vt[7] = '{0, 0, 8'h00, 8'h1C, 0, 1};
        vt[8] = '{0, 0, 8'h00, 8'h19, 0, 1};

        do_reset();
        chk("reset_cur", bus.current_out, 0);
        chk("reset_seen", bus.spike_seen, 0);
        chk("reset_act", bus.active, 0);

        for (int i = 0; i < 9; i++) begin
            cyc(vt[i].s, vt[i].wl, vt[i].wi);
            chk($sformatf("vec%0d_cur", i), bus.current_out, vt[i].cur);
            chk($sformatf("vec%0d_seen", i), bus.spike_seen, vt[i].seen);
            chk($sformatf("vec%0d_act", i), bus.active, vt[i].act);
        end

        do_reset();
        seen_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0);
            if (i == 0) chk("held_cur", bus.current_out, 'h20);
            seen_cnt += int'(bus.spike_seen);
        end
        chk("held_once", seen_cnt, 1);

        do_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("refr_drop_seen", bus.spike_seen, 0);
        chk("refr_drop_cur", bus.current_out, 'h20);

        do_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("refr_after_seen", bus.spike_seen, 1);
        chk("refr_after_cur", bus.current_out, 'h40);

        cyc(0, 0, 0);
        cyc(0, 1, 8'h77);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cur", bus.current_out, 0);
        chk("async_rst_act", bus.active, 0);
        chk("async_rst_seen", bus.spike_seen, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 0);
        chk("rst_weight", bus.current_out, 'h20);

        do_reset();
        cyc(0, 1, 8'hF0);
        cyc(1, 0, 0);
        chk("sat_first", bus.current_out, 'hF0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("sat_clamp", bus.current_out, 'hFF);

        do_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("tick_and_spike", bus.current_out, 'h3C);

        do_reset();
        cyc(1, 1, 8'h05);
        chk("wl_coinc_old", bus.current_out, 'h20);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("wl_coinc_new", bus.current_out, 'h25);

        do_reset();
        cyc(0, 1, 8'h05);
        cyc(1, 0, 0);
        chk("tail_start", bus.current_out, 5);
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < 3; j++) cyc(0, 0, 0);
            chk($sformatf("tail_act_pre%0d", k), bus.active, 1);
            cyc(0, 0, 0);
            chk($sformatf("tail_cur%0d", k), bus.current_out, 5 - k);
        end
        chk("tail_idle", bus.active, 0);

        do_reset();
        cyc(0, 1, 8'h00);
        cyc(1, 0, 0);
        chk("w0_seen", bus.spike_seen, 1);
        chk("w0_act", bus.active, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("w0_exit", bus.active, 0);

        do_reset();
        m_init();
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 99) < 35);
            wl = ($urandom_range(0, 99) < 5);
            wi = ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(0, 255)) :
                 int'($urandom_range(0, 24));
            cyc(s, wl, 8'(wi));
            m_step(s, wl, wi);
            chk($sformatf("rnd%0d_cur", i), bus.current_out, m_cur);
            chk($sformatf("rnd%0d_seen", i), bus.spike_seen, m_seen);
            chk($sformatf("rnd%0d_act", i), bus.active, m_act);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
